bmi_select_unit: RTL and testbench

- Multi-cycle BMI "select" unit: the inverse of the ALU's population-count path.
- Popcount answers "how many set bits". Select answers "at which position is the n-th set bit".
- Takes a DATA_WIDTH operand and a 0-based rank, scans one CHUNK_WIDTH slice per cycle, and returns the bit index of the rank-th set bit.
- Sits beside the popcount unit in the BMI ALU, behind a valid/ready handshake on both sides.

---
 rtl/bmi_pkg.sv | 12 +
 rtl/bmi_select_unit_if.sv | 32 +++
 rtl/bmi_chunk_select.sv | 34 +++
 rtl/bmi_select_unit.sv | 147 ++++++++++++++
 tb/tb_bmi_select_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bmi_pkg.sv
// Shared constants and state encoding for the BMI select unit.
package bmi_pkg;

   localparam int DEF_DATA_WIDTH  = 256;
   localparam int DEF_CHUNK_WIDTH = 32;
   localparam int NCHUNK          = DEF_DATA_WIDTH / DEF_CHUNK_WIDTH;
   localparam int POS_W           = $clog2(DEF_DATA_WIDTH);
   localparam int CNT_W           = $clog2(DEF_CHUNK_WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} select_state_t;

endpackage

// File: rtl/bmi_select_unit_if.sv
// Request/result handshake bundle for bmi_select_unit.
// Carries pop_total only when BMI_SELECT_TOTAL_EN is defined.
interface bmi_select_unit_if
   import bmi_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   localparam int PW = $clog2(DATA_WIDTH);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] data_in;
   logic [PW-1:0]         rank_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [PW-1:0]         pos_out;
   logic                  found;
`ifdef BMI_SELECT_TOTAL_EN
   logic [PW:0]           pop_total;

   modport master (output in_valid, data_in, rank_in, out_ready,
                   input  in_ready, out_valid, pos_out, found, pop_total);
   modport slave  (input  in_valid, data_in, rank_in, out_ready,
                   output in_ready, out_valid, pos_out, found, pop_total);
`else
   modport master (output in_valid, data_in, rank_in, out_ready,
                   input  in_ready, out_valid, pos_out, found);
   modport slave  (input  in_valid, data_in, rank_in, out_ready,
                   output in_ready, out_valid, pos_out, found);
`endif

endinterface

// File: rtl/bmi_chunk_select.sv
// Combinational per-chunk select: popcount of the chunk and, when rem < popcount,
// the LSB-relative offset of the rem-th set bit.
module bmi_chunk_select
   import bmi_pkg::*;
#(
   parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH,
   parameter int REM_W       = POS_W
) (
   input  logic [CHUNK_WIDTH-1:0]         chunk,
   input  logic [REM_W-1:0]               rem,
   output logic [$clog2(CHUNK_WIDTH):0]   cnt,
   output logic                           hit,
   output logic [$clog2(CHUNK_WIDTH)-1:0] offset
);
   localparam int CW = $clog2(CHUNK_WIDTH) + 1;
   localparam int OW = $clog2(CHUNK_WIDTH);

   // The running count before a set bit equals its 0-based rank inside the chunk.
   always_comb begin
      cnt    = '0;
      hit    = 1'b0;
      offset = '0;
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
         if (chunk[i]) begin
            if (!hit && (int'(cnt) == int'(rem))) begin
               hit    = 1'b1;
               offset = OW'(i);
            end
            cnt = cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/bmi_select_unit.sv
// Multi-cycle BMI select: locates the rank-th set bit, one chunk per cycle.
// BMI_SELECT_TOTAL_EN: always scans every chunk and also reports pop_total.
module bmi_select_unit
   import bmi_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
   input logic               clk,
   input logic               rst,
   bmi_select_unit_if.slave  bus
);
   localparam int NCHK = DATA_WIDTH / CHUNK_WIDTH;
   localparam int PW   = $clog2(DATA_WIDTH);
   localparam int CNTW = $clog2(CHUNK_WIDTH) + 1;
   localparam int OW   = $clog2(CHUNK_WIDTH);
   localparam int IW   = (NCHK > 1) ? $clog2(NCHK) : 1;

   select_state_t         state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic [PW-1:0]         rem_q;
   logic [IW-1:0]         idx_q;
   logic [PW-1:0]         pos_q;
   logic                  found_q;
`ifdef BMI_SELECT_TOTAL_EN
   logic [PW:0]           total_q;
`endif

   logic [CHUNK_WIDTH-1:0] chunk;
   logic [CNTW-1:0]        cnt;
   logic                   hit;
   logic [OW-1:0]          offset;
   logic [PW-1:0]          hit_pos;
   logic                   last;
   logic                   accept;
   logic                   in_ready_c;
   logic                   out_valid_c;

   assign chunk   = data_q[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
   assign last    = (idx_q == IW'(NCHK - 1));
   assign hit_pos = PW'(int'(idx_q) * CHUNK_WIDTH) + PW'(offset);

   bmi_chunk_select #(
      .CHUNK_WIDTH (CHUNK_WIDTH),
      .REM_W       (PW)
   ) u_chunk (
      .chunk  (chunk),
      .rem    (rem_q),
      .cnt    (cnt),
      .hit    (hit),
      .offset (offset)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = !rst;
            accept     = bus.in_valid && !rst;
            if (accept) state_d = SCAN;
         end
         SCAN: begin
`ifdef BMI_SELECT_TOTAL_EN
            if (last) state_d = DONE;
`else
            if (hit || last) state_d = DONE;
`endif
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand is only consumed while scanning, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) data_q <= bus.data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q   <= '0;
         idx_q   <= '0;
         pos_q   <= '0;
         found_q <= 1'b0;
`ifdef BMI_SELECT_TOTAL_EN
         total_q <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  rem_q   <= bus.rank_in;
                  idx_q   <= '0;
                  pos_q   <= '0;
                  found_q <= 1'b0;
`ifdef BMI_SELECT_TOTAL_EN
                  total_q <= '0;
`endif
               end
            end
            SCAN: begin
`ifdef BMI_SELECT_TOTAL_EN
               total_q <= total_q + (PW+1)'(cnt);
               if (!found_q) begin
                  if (hit) begin
                     pos_q   <= hit_pos;
                     found_q <= 1'b1;
                  end else begin
                     rem_q <= rem_q - PW'(cnt);
                  end
               end
               if (!last) idx_q <= idx_q + IW'(1);
`else
               if (hit) begin
                  pos_q   <= hit_pos;
                  found_q <= 1'b1;
               end else if (!last) begin
                  rem_q <= rem_q - PW'(cnt);
                  idx_q <= idx_q + IW'(1);
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.pos_out   = pos_q;
   assign bus.found     = found_q;
`ifdef BMI_SELECT_TOTAL_EN
   assign bus.pop_total = total_q;
`endif

endmodule

// File: tb/tb_bmi_select_unit.sv
// Table-driven, scoreboard-checked bench for bmi_select_unit.
module tb_bmi_select_unit;
   import bmi_pkg::*;

   localparam int NCH = NCHUNK;
   localparam int CHW = DEF_CHUNK_WIDTH;
`ifdef BMI_SELECT_TOTAL_EN
   localparam bit TOTAL_EN = 1'b1;
`else
   localparam bit TOTAL_EN = 1'b0;
`endif

   typedef struct {
      logic [255:0] data;
      int           rank;
      int           exp_pos;
      bit           exp_found;
      string        tag;
   } vec_t;

   typedef struct {
      int pos;
      bit found;
      int lat;
      int total;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   vec_t vecs[$];
   exp_t sb[$];

   bmi_select_unit_if #(.DATA_WIDTH(DEF_DATA_WIDTH)) bus ();

   bmi_select_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void ref_select(input logic [255:0] d, input int rank,
                                      output int pos, output bit fnd);
      int c = 0;
      pos = 0;
      fnd = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if (d[i]) begin
            if (c == rank && !fnd) begin
               pos = i;
               fnd = 1'b1;
            end
            c++;
         end
      end
   endfunction

   // Edges from acceptance until out_valid is visible.
   function automatic int ref_lat(input bit fnd, input int pos);
      if (TOTAL_EN || !fnd) return NCH;
      return pos / CHW + 1;
   endfunction

   task automatic run_op(input logic [255:0] d, input int r, input int exp_pos,
                         input bit exp_found, input int hold, input string tag);
      exp_t e;
      int   n;
      int   p0;
      int   f0;
      e.pos   = exp_pos;
      e.found = exp_found;
      e.lat   = ref_lat(exp_found, exp_pos);
      e.total = $countones(d);
      sb.push_back(e);

      bus.data_in   = d;
      bus.rank_in   = 8'(r);
      bus.in_valid  = 1'b1;
      bus.out_ready = (hold == 0);
      check({tag, "_in_ready_idle"}, int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check({tag, "_in_ready_busy"}, int'(bus.in_ready), 0);

      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk);
         n++;
         #1;
      end
      e = sb.pop_front();
      if (!bus.out_valid) begin
         check({tag, "_timeout"}, 0, 1);
         return;
      end
      check({tag, "_latency"}, n, e.lat);
      check({tag, "_pos"}, int'(bus.pos_out), e.pos);
      check({tag, "_found"}, int'(bus.found), int'(e.found));
`ifdef BMI_SELECT_TOTAL_EN
      check({tag, "_pop_total"}, int'(bus.pop_total), e.total);
`endif

      p0 = int'(bus.pos_out);
      f0 = int'(bus.found);
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'b1;
         bus.data_in  = ~d;
         bus.rank_in  = '0;
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, int'(bus.out_valid), 1);
         check({tag, "_hold_pos"}, int'(bus.pos_out), p0);
         check({tag, "_hold_found"}, int'(bus.found), f0);
         check({tag, "_hold_in_ready"}, int'(bus.in_ready), 0);
      end

      // in_valid stays high through the handshake edge when backpressured.
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check({tag, "_post_valid"}, int'(bus.out_valid), 0);
      check({tag, "_post_in_ready"}, int'(bus.in_ready), 1);
   endtask

   initial begin
      logic [255:0] d;
      int           r;
      int           p;
      bit           f;
      vec_t         v;

      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.data_in   = '0;
      bus.rank_in   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(bus.in_ready), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_pos", int'(bus.pos_out), 0);
      check("rst_found", int'(bus.found), 0);
      rst = 1'b0;
      #1;
      check("rst_release_in_ready", int'(bus.in_ready), 1);

      d = '0; d[0] = 1'b1;
      vecs.push_back('{d, 0, 0, 1'b1, "bit0"});
      d = '0; d[5] = 1'b1; d[200] = 1'b1;
      vecs.push_back('{d, 1, 200, 1'b1, "bit200"});
      vecs.push_back('{{256{1'b1}}, 255, 255, 1'b1, "ones_r255"});
      vecs.push_back('{{256{1'b1}}, 31, 31, 1'b1, "ones_r31"});
      vecs.push_back('{{256{1'b1}}, 32, 32, 1'b1, "ones_r32"});
      vecs.push_back('{256'h0, 0, 0, 1'b0, "zero"});
      vecs.push_back('{256'hFF, 8, 0, 1'b0, "ff_r8"});
      d = '0; d[31:0] = 32'hF000_000F;
      vecs.push_back('{d, 7, 31, 1'b1, "chunk_edge"});
      d = '0; d[3:0] = 4'hF; d[100] = 1'b1;
      vecs.push_back('{d, 4, 100, 1'b1, "eq_rem_adv"});
      for (int k = 0; k < 5; k++) begin
         for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom() & $urandom();
         r = $urandom_range(0, ($countones(d) + 1 > 255) ? 255 : $countones(d) + 1);
         ref_select(d, r, p, f);
         v.data = d; v.rank = r; v.exp_pos = p; v.exp_found = f;
         v.tag = $sformatf("rand%0d", k);
         vecs.push_back(v);
      end

      foreach (vecs[i]) run_op(vecs[i].data, vecs[i].rank, vecs[i].exp_pos,
                                vecs[i].exp_found, 0, vecs[i].tag);

      d = '0; d[5] = 1'b1; d[200] = 1'b1;
      run_op(d, 1, 200, 1'b1, 5, "backpressure");

      // Abort in the third scan cycle, then a fresh request must run cleanly.
      bus.data_in  = '1;
      bus.rank_in  = 8'd255;
      bus.in_valid = 1'b1;
      check("abort_in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_out_valid", int'(bus.out_valid), 0);
      check("abort_found", int'(bus.found), 0);
      rst = 1'b0;
      #1;
      check("abort_idle", int'(bus.in_ready), 1);
      d = '0; d[77] = 1'b1;
      run_op(d, 0, 77, 1'b1, 0, "after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
